event_encoder: RTL and testbench
================================

// Module: event_encoder
// PURPOSE
//   Registered priority encoder: the opposite direction of the 2-to-4 decoder.
//   Captures N event-request lines into a sticky pending register.
//   Issues one binary code per event, highest priority first, over a valid/ready handshake.
//   Sits between interrupt/event sources and a consumer that indexes a decoder or handler table.
// PARAMETERS
//   N            4  number of request lines (>=2)
//   CODE_W       2  code width; must equal $clog2(N) (elaboration error otherwise)
//   PRIORITY_MSB 1  1: highest index wins; 0: lowest index wins
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   en           in   1       capture enable; 0 = req_in ignored
//   clear_in     in   1       synchronous flush of all state
//   req_in       in   N       event requests, sampled each cycle when en=1
//   ready_in     in   1       consumer accepts code_out this cycle
//   code_out     out  CODE_W  encoded index of the issued event
//   valid_out    out  1       code_out holds an unaccepted event
//   pending_out  out  N       events captured but not yet issued
//   overflow_out out  1       1-cycle pulse: event merged into an already-pending bit
// BEHAVIOUR
//   Reset (rst_n=0, async): pending, code_out, valid_out, overflow_out = 0; held until release.
//   Per cycle:
//     new   = en ? req_in : 0
//     avail = pending | new
//     accept = valid_out & ready_in
//     can_load = !valid_out | ready_in
//     sel = priority index of avail, per PRIORITY_MSB
//   clear_in=1 overrides everything: all registers <= 0; req_in that cycle is dropped.
//   Load (can_load & avail!=0):
//     code_out <= sel; valid_out <= 1; pending <= avail & ~onehot(sel).
//   No load:
//     pending <= avail.
//     If accept & avail==0: valid_out <= 0, code_out keeps last value.
//   Latency: req_in high in cycle k (en=1, output free) -> valid_out/code_out in cycle k+1.
//   Throughput: one code per cycle while ready_in=1.
//   Stall: valid_out=1 & ready_in=0 -> code_out and valid_out held stable; capture continues.
//   A request for the index currently in code_out is a new event; it goes to pending.
//   Overflow: overflow_out <= en & |(req_in & pending) (registered, 1 cycle); event counted once.
//   en=0: no capture; pending still drains normally.
//   rst_n asserted mid-transfer: everything lost; no code issues after release until new req_in.
// TESTING
//   1. Reset mid-op: pending=1010, valid_out=1, pull rst_n low
//      -> all outputs 0 immediately; stay 0 after release with req_in=0.
//   2. Single event: en=1, ready_in=1, req_in=0100 for 1 cycle
//      -> next cycle valid_out=1, code_out=10; following cycle valid_out=0.
//   3. Multi event: req_in=1011 for 1 cycle, ready_in=1
//      -> PRIORITY_MSB=1: codes 11,01,00 on consecutive cycles, pending 0011->0001->0000.
//      -> PRIORITY_MSB=0: codes 00,01,11.
//   4. Backpressure: ready_in=0, req_in=0001 then 1000
//      -> code_out=00 held with valid_out=1, pending=1000.
//      -> raise ready_in: next cycle code_out=11; then valid_out=0.
//   5. Overflow: ready_in=0, code_out busy, pending[1]=1, req_in=0010 again
//      -> overflow_out=1 for exactly 1 cycle; code 01 issued once only.
//   6. Gating and flush: en=0, req_in=1111 -> pending stays 0000, valid_out=0.
//      -> then clear_in=1 with pending=0110, valid_out=1: all 0 next cycle.

Source files
------------

// File: rtl/event_encoder.sv
// Registered priority encoder: captures event requests into a sticky pending
// register and issues one binary code per event over a valid/ready handshake.
module event_encoder #(
  parameter int N            = 4,
  parameter int CODE_W       = 2,
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear_in,
  input  logic [N-1:0]      req_in,
  input  logic              ready_in,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  output logic [N-1:0]      pending_out,
  output logic              overflow_out
);

  if (N < 2) begin : g_bad_n
    $error("event_encoder: N must be at least 2");
  end
  if (CODE_W != $clog2(N)) begin : g_bad_code_w
    $error("event_encoder: CODE_W must equal $clog2(N)");
  end

  // Winning index of v; the scan order makes the last hit the winner.
  function automatic logic [CODE_W-1:0] prio_sel(input logic [N-1:0] v);
    logic [CODE_W-1:0] r;
    r = {CODE_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (PRIORITY_MSB) begin
        r = v[i] ? CODE_W'(i) : r;
      end else begin
        r = v[N-1-i] ? CODE_W'(N-1-i) : r;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  logic [N-1:0]      pending_r;
  logic [CODE_W-1:0] code_r;
  logic              valid_r;
  logic              overflow_r;

  logic [N-1:0]      new_s;
  logic [N-1:0]      avail_s;
  logic [CODE_W-1:0] sel_s;
  logic              can_load_s;
  logic              accept_s;

  // Next-event selection from captured plus newly arriving requests.
  always_comb begin
    new_s      = en ? req_in : {N{1'b0}};
    avail_s    = pending_r | new_s;
    sel_s      = prio_sel(avail_s);
    can_load_s = !valid_r || ready_in;
    accept_s   = valid_r && ready_in;
  end

  // Pending capture, code issue and overflow flag; clear_in drops even this cycle's requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= {N{1'b0}};
      code_r     <= {CODE_W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (clear_in) begin
      pending_r  <= {N{1'b0}};
      code_r     <= {CODE_W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= en && (|(req_in & pending_r));
      if (can_load_s && (avail_s != {N{1'b0}})) begin
        code_r    <= sel_s;
        valid_r   <= 1'b1;
        pending_r <= avail_s & ~onehot(sel_s);
      end else begin
        pending_r <= avail_s;
        code_r    <= code_r;
        // Reaching here with accept means nothing is left to issue.
        if (accept_s) begin
          valid_r <= 1'b0;
        end else begin
          valid_r <= valid_r;
        end
      end
    end
  end

  assign code_out     = code_r;
  assign valid_out    = valid_r;
  assign pending_out  = pending_r;
  assign overflow_out = overflow_r;

endmodule

// File: tb/tb_event_encoder.sv
// Directed self-checking bench for event_encoder; a second instance with
// PRIORITY_MSB=0 shares the stimulus to check low-index-first ordering.
module tb_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clear_in;
  logic [3:0] req_in;
  logic       ready_in;

  logic [1:0] code_m, code_l;
  logic       valid_m, valid_l;
  logic [3:0] pend_m, pend_l;
  logic       ovf_m, ovf_l;

  int n_cmp = 0;
  int n_err = 0;

  event_encoder #(.N(4), .CODE_W(2), .PRIORITY_MSB(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .clear_in(clear_in), .req_in(req_in),
    .ready_in(ready_in), .code_out(code_m), .valid_out(valid_m),
    .pending_out(pend_m), .overflow_out(ovf_m)
  );

  event_encoder #(.N(4), .CODE_W(2), .PRIORITY_MSB(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .clear_in(clear_in), .req_in(req_in),
    .ready_in(ready_in), .code_out(code_l), .valid_out(valid_l),
    .pending_out(pend_l), .overflow_out(ovf_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs of the MSB-priority instance.
  task automatic chk_m(input string tag, input logic v, input logic [1:0] c,
                       input logic [3:0] p, input logic o);
    chk({tag, ".valid"}, 32'(valid_m), 32'(v));
    chk({tag, ".code"},  32'(code_m),  32'(c));
    chk({tag, ".pend"},  32'(pend_m),  32'(p));
    chk({tag, ".ovf"},   32'(ovf_m),   32'(o));
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    clear_in = 1'b0;
    req_in   = 4'b0000;
    ready_in = 1'b0;
    tick();
    tick();
    chk_m("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_m("post_reset_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Single event
    en = 1'b1; ready_in = 1'b1; req_in = 4'b0100;
    tick();
    chk_m("single_issue", 1'b1, 2'd2, 4'b0000, 1'b0);
    req_in = 4'b0000;
    tick();
    chk_m("single_done", 1'b0, 2'd2, 4'b0000, 1'b0);

    // Multi event, both priority orders
    req_in = 4'b1011;
    tick();
    chk_m("multi_1", 1'b1, 2'd3, 4'b0011, 1'b0);
    chk("multi_1.lsb_code", 32'(code_l), 32'd0);
    chk("multi_1.lsb_pend", 32'(pend_l), 32'b1010);
    req_in = 4'b0000;
    tick();
    chk_m("multi_2", 1'b1, 2'd1, 4'b0001, 1'b0);
    chk("multi_2.lsb_code", 32'(code_l), 32'd1);
    chk("multi_2.lsb_pend", 32'(pend_l), 32'b1000);
    tick();
    chk_m("multi_3", 1'b1, 2'd0, 4'b0000, 1'b0);
    chk("multi_3.lsb_code", 32'(code_l), 32'd3);
    chk("multi_3.lsb_valid", 32'(valid_l), 32'd1);
    tick();
    chk_m("multi_end", 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("multi_end.lsb_valid", 32'(valid_l), 32'd0);

    // Backpressure
    ready_in = 1'b0; req_in = 4'b0001;
    tick();
    chk_m("bp_first", 1'b1, 2'd0, 4'b0000, 1'b0);
    req_in = 4'b1000;
    tick();
    chk_m("bp_capture", 1'b1, 2'd0, 4'b1000, 1'b0);
    req_in = 4'b0000;
    tick();
    chk_m("bp_hold", 1'b1, 2'd0, 4'b1000, 1'b0);
    ready_in = 1'b1;
    tick();
    chk_m("bp_release", 1'b1, 2'd3, 4'b0000, 1'b0);
    tick();
    chk_m("bp_done", 1'b0, 2'd3, 4'b0000, 1'b0);

    // Overflow
    ready_in = 1'b0; req_in = 4'b0001;
    tick();
    chk_m("ovf_busy", 1'b1, 2'd0, 4'b0000, 1'b0);
    req_in = 4'b0010;
    tick();
    chk_m("ovf_first", 1'b1, 2'd0, 4'b0010, 1'b0);
    tick();
    chk_m("ovf_pulse", 1'b1, 2'd0, 4'b0010, 1'b1);
    req_in = 4'b0000;
    tick();
    chk_m("ovf_drop", 1'b1, 2'd0, 4'b0010, 1'b0);
    ready_in = 1'b1;
    tick();
    chk_m("ovf_issue", 1'b1, 2'd1, 4'b0000, 1'b0);
    tick();
    chk_m("ovf_once", 1'b0, 2'd1, 4'b0000, 1'b0);
    tick();
    chk_m("ovf_once2", 1'b0, 2'd1, 4'b0000, 1'b0);

    // en=0 drains pending without capturing
    req_in = 4'b0011;
    tick();
    chk_m("drain_1", 1'b1, 2'd1, 4'b0001, 1'b0);
    en = 1'b0; req_in = 4'b1111;
    tick();
    chk_m("drain_2", 1'b1, 2'd0, 4'b0000, 1'b0);
    tick();
    chk_m("gate_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Flush with state present
    en = 1'b1; ready_in = 1'b0; req_in = 4'b0001;
    tick();
    chk_m("flush_busy", 1'b1, 2'd0, 4'b0000, 1'b0);
    req_in = 4'b0110;
    tick();
    chk_m("flush_pend", 1'b1, 2'd0, 4'b0110, 1'b0);
    req_in = 4'b1111; clear_in = 1'b1;
    tick();
    chk_m("flush", 1'b0, 2'd0, 4'b0000, 1'b0);
    clear_in = 1'b0; req_in = 4'b0000;
    tick();
    chk_m("flush_dropped", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Asynchronous reset mid-transfer
    req_in = 4'b0010;
    tick();
    req_in = 4'b1010;
    tick();
    chk_m("mid_busy", 1'b1, 2'd1, 4'b1010, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_m("mid_reset_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    req_in = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    chk_m("mid_release", 1'b0, 2'd0, 4'b0000, 1'b0);
    ready_in = 1'b1;
    tick();
    chk_m("mid_quiet", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
